// File: rtl/ddc_acc_pkg.sv
// Shared constants, lane structs and window-length clamp for the DDC I/Q
// boxcar accumulator.
package ddc_acc_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int LOG_MAX_ACC = 16;
  localparam int ACC_WIDTH   = DATA_WIDTH + LOG_MAX_ACC;

  // I occupies the LSBs, Q the MSBs, matching the 64-bit stream layout.
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] q;
    logic signed [DATA_WIDTH-1:0] i;
  } iq_t;

  typedef struct packed {
    logic signed [ACC_WIDTH-1:0] q;
    logic signed [ACC_WIDTH-1:0] i;
  } acc_t;

  // Window lengths beyond the accumulator headroom fall back to the maximum.
  function automatic logic [4:0] clamp_log2(input logic [4:0] v);
    return (v > 5'(LOG_MAX_ACC)) ? 5'(LOG_MAX_ACC) : v;
  endfunction

endpackage

// File: rtl/ddc_acc_fifo.sv
// Two-entry in-order I/Q result buffer. A push while full is accepted only
// when a pop happens in the same cycle.
module ddc_acc_fifo
  import ddc_acc_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  iq_t  i_data,
  input  logic i_pop,
  output iq_t  o_head,
  output logic o_full,
  output logic o_empty
);

  iq_t        r_mem [2];
  logic       r_wr;
  logic       r_rd;
  logic [1:0] r_cnt;

  logic w_push;
  logic w_pop;

  assign w_pop   = i_pop && (r_cnt != 2'd0);
  assign w_push  = i_push && ((r_cnt != 2'd2) || w_pop);
  assign o_head  = r_mem[r_rd];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

  // Storage, pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < 2; k++) r_mem[k] <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/ddc_iq_accumulator.sv
// Accumulate-and-dump boxcar decimator for the DDC baseband I/Q stream.
// Averages 2^acc_log2 samples per window and emits one result per window
// through a 2-entry AXI-Stream buffer with a sticky drop flag.
// Optional macro DDC_ACC_ROUND_EN: round-half-up with positive saturation
// instead of a plain floor shift.
module ddc_iq_accumulator
  import ddc_acc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 s_axis_aclk,
  input  logic                 rst,
  input  logic [63:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 resync,
  input  logic [4:0]           acc_log2,
  output logic [63:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] win_count
);

  localparam int SCW = LOG_MAX_ACC + 1;

  acc_t                 r_acc;
  logic [SCW-1:0]       r_cnt;
  logic [4:0]           r_shift;
  logic                 r_dump;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_win_count;

  iq_t            w_in;
  acc_t           w_ext;
  logic           w_start;
  logic [4:0]     w_shift_eff;
  logic [SCW-1:0] w_cnt_inc;
  logic           w_last;
  iq_t            w_res;
  iq_t            w_head;
  logic           w_full;
  logic           w_empty;
  logic           w_pop;
  logic           w_push;
  logic           w_drop;

`ifdef DDC_ACC_ROUND_EN
  function automatic logic [DATA_WIDTH-1:0] dump_lane(
    input logic signed [ACC_WIDTH-1:0] s,
    input logic        [4:0]           sh
  );
    logic signed [ACC_WIDTH:0] bias;
    logic signed [ACC_WIDTH:0] t;
    bias = '0;
    if (sh != 5'd0) bias = (ACC_WIDTH+1)'(1) << (sh - 5'd1);
    t = ($signed({s[ACC_WIDTH-1], s}) + bias) >>> sh;
    // Rounding can only push upward, so only the positive limit is guarded.
    if (!t[ACC_WIDTH] && (|t[ACC_WIDTH-1:DATA_WIDTH-1]))
      return {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return t[DATA_WIDTH-1:0];
  endfunction
`else
  function automatic logic [DATA_WIDTH-1:0] dump_lane(
    input logic signed [ACC_WIDTH-1:0] s,
    input logic        [4:0]           sh
  );
    logic signed [ACC_WIDTH-1:0] t;
    t = s >>> sh;
    return t[DATA_WIDTH-1:0];
  endfunction
`endif

  assign w_in    = s_axis_tdata;
  assign w_ext.i = {{LOG_MAX_ACC{w_in.i[DATA_WIDTH-1]}}, w_in.i};
  assign w_ext.q = {{LOG_MAX_ACC{w_in.q[DATA_WIDTH-1]}}, w_in.q};

  // A zero sample count means no window is open; resync forces a fresh one.
  assign w_start     = s_axis_tvalid && (resync || (r_cnt == '0));
  assign w_shift_eff = w_start ? clamp_log2(acc_log2) : r_shift;
  assign w_cnt_inc   = w_start ? SCW'(1) : r_cnt + SCW'(1);
  assign w_last      = (w_cnt_inc == (SCW'(1) << w_shift_eff));

  // Window sum, sample count and latched shift.
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_dump  <= 1'b0;
    end else begin
      r_dump <= s_axis_tvalid && w_last;
      if (s_axis_tvalid) begin
        r_shift <= w_shift_eff;
        r_acc.i <= w_start ? w_ext.i : r_acc.i + w_ext.i;
        r_acc.q <= w_start ? w_ext.q : r_acc.q + w_ext.q;
        r_cnt   <= w_last ? '0 : w_cnt_inc;
      end else if (resync) begin
        r_cnt <= '0;
      end
    end
  end

  // Dump is taken from the registered final sum in the cycle after the last
  // sample; a new window loading in that cycle only overwrites it at the edge.
  always_comb begin
    w_res   = '0;
    w_res.i = dump_lane(r_acc.i, r_shift);
    w_res.q = dump_lane(r_acc.q, r_shift);
  end

  assign w_pop  = m_axis_tvalid && m_axis_tready;
  assign w_push = r_dump && (!w_full || w_pop);
  assign w_drop = r_dump && w_full && !w_pop;

  ddc_acc_fifo u_fifo (
    .i_clk   (s_axis_aclk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (w_res),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Sticky drop flag (a coincident drop beats resync) and window counter.
  always_ff @(posedge s_axis_aclk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_win_count <= '0;
    end else begin
      if (w_drop)      r_overflow <= 1'b1;
      else if (resync) r_overflow <= 1'b0;
      if (w_push) r_win_count <= r_win_count + 1'b1;
    end
  end

  assign m_axis_tdata  = w_head;
  assign m_axis_tvalid = !w_empty;
  assign overflow      = r_overflow;
  assign win_count     = r_win_count;

endmodule

// File: tb/tb_ddc_iq_accumulator.sv
// Scoreboard bench for ddc_iq_accumulator: the stimulus side queues the
// hand-computed averages, a negedge monitor pops them on each handshake.
module tb_ddc_iq_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_tdata;
  logic        s_tvalid;
  logic        resync;
  logic [4:0]  acc_log2;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        ovf;
  logic [15:0] win_count;

  int total = 0;
  int bad   = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  ddc_iq_accumulator #(.CNT_WIDTH(16)) dut (
    .s_axis_aclk   (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .resync        (resync),
    .acc_log2      (acc_log2),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .overflow      (ovf),
    .win_count     (win_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h expected=none", m_tdata);
      end else begin
        chk("sb_data", m_tdata, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    s_tdata  = {q[31:0], i[31:0]};
    s_tvalid = 1'b1;
    step();
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    rst = 1'b1;
    step();
    sb.delete();
    step();
    rst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    s_tdata  = '0;
    s_tvalid = 1'b0;
    resync   = 1'b0;
    acc_log2 = 5'd0;
    m_tready = 1'b1;
    rst      = 1'b1;
    step();
    do_reset();

    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", m_tdata, 64'd0);
    chk("rst_overflow", 64'(ovf), 64'd0);
    chk("rst_win_count", 64'(win_count), 64'd0);

    // Window of 1: pass-through, two-cycle latency, one result per cycle.
    acc_log2 = 5'd0;
    for (int k = 1; k <= 6; k++) begin
      sb.push_back({32'hFFFF_FFFD, 32'd5});
      send(5, -3);
      chk("w1_tvalid", 64'(m_tvalid), (k >= 2) ? 64'd1 : 64'd0);
      chk("w1_win_count", 64'(win_count), 64'(k - 1));
    end
    idle(2);
    chk("w1_win_count_end", 64'(win_count), 64'd6);
    drain(10);

    // Window of 4 with a floor (or rounded) average.
    acc_log2 = 5'd2;
`ifdef DDC_ACC_ROUND_EN
    sb.push_back({32'hFFFF_FFFE, 32'd3});
`else
    sb.push_back({32'hFFFF_FFFD, 32'd2});
`endif
    for (int k = 1; k <= 4; k++) send(k, -k);
    idle(1);
    drain(10);
    chk("w4_win_count", 64'(win_count), 64'd7);

    // Stalled output: two results buffered, the third is dropped.
    do_reset();
    m_tready = 1'b0;
    acc_log2 = 5'd0;
    sb.push_back({32'hFFFF_FFFF, 32'd10});
    sb.push_back({32'hFFFF_FFFE, 32'd20});
    send(10, -1);
    send(20, -2);
    send(30, -3);
    idle(2);
    chk("stall_tvalid", 64'(m_tvalid), 64'd1);
    chk("stall_head", m_tdata, {32'hFFFF_FFFF, 32'd10});
    chk("stall_overflow", 64'(ovf), 64'd1);
    idle(1);
    chk("stall_hold", m_tdata, {32'hFFFF_FFFF, 32'd10});
    m_tready = 1'b1;
    drain(10);
    chk("stall_win_count", 64'(win_count), 64'd2);

    // Resync mid-window: partial sum discarded, overflow cleared,
    // mid-window acc_log2 change ignored.
    acc_log2 = 5'd3;
    for (int k = 0; k < 5; k++) send(1000, -1000);
    chk("pre_resync_overflow", 64'(ovf), 64'd1);
`ifdef DDC_ACC_ROUND_EN
    sb.push_back({32'hFFFF_FFFC, 32'd5});
`else
    sb.push_back({32'hFFFF_FFFB, 32'd4});
`endif
    resync = 1'b1;
    send(1, -1);
    resync = 1'b0;
    chk("resync_overflow", 64'(ovf), 64'd0);
    acc_log2 = 5'd0;
    for (int k = 2; k <= 8; k++) begin
      send(k, -k);
      if (k < 8) chk("resync_no_out", 64'(m_tvalid), 64'd0);
    end
    s_tvalid = 1'b0;
    chk("resync_lat1", 64'(m_tvalid), 64'd0);
    step();
    chk("resync_lat2", 64'(m_tvalid), 64'd1);
    drain(10);
    chk("resync_win_count", 64'(win_count), 64'd3);

    // Maximum window (acc_log2 clamped from 20) at full-scale input.
    acc_log2 = 5'd20;
    sb.push_back({32'h7FFF_FFFF, 32'h7FFF_FFFF});
    for (int k = 0; k < 65536; k++) begin
      send(32'h7FFF_FFFF, 32'h7FFF_FFFF);
      if (k == 65534) chk("max_no_early_out", 64'(m_tvalid), 64'd0);
    end
    idle(1);
    drain(10);
    chk("max_win_count", 64'(win_count), 64'd4);

    // Reset mid-window with a full buffer and overflow set.
    m_tready = 1'b0;
    acc_log2 = 5'd0;
    send(1, 1);
    send(2, 2);
    send(3, 3);
    idle(2);
    chk("pre_rst_overflow", 64'(ovf), 64'd1);
    acc_log2 = 5'd2;
    send(1000, 1000);
    send(1000, 1000);
    s_tvalid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("mid_rst_overflow", 64'(ovf), 64'd0);
    chk("mid_rst_win_count", 64'(win_count), 64'd0);
    m_tready = 1'b1;
    sb.push_back({32'hFFFF_FFF8, 32'd8});
    for (int k = 0; k < 4; k++) send(8, -8);
    idle(1);
    drain(10);
    chk("post_rst_win_count", 64'(win_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddc_iq_accumulator.md
Name: ddc_iq_accumulator

Overview:
- Downstream of ddc_core. Consumes the 64-bit baseband I/Q stream and averages it over a programmable window of 2^acc_log2 samples (accumulate-and-dump boxcar decimator).
- Emits one averaged I/Q word per window on an AXI-Stream master with backpressure, a 2-entry output buffer and a sticky overflow flag.
- Lowers the DDC sample rate before packetisation/DMA.

Parameters:
- DATA_WIDTH, 32, width of each I and Q lane, in and out.
- LOG_MAX_ACC, 16, maximum log2 window length.
- ACC_WIDTH, DATA_WIDTH+LOG_MAX_ACC (48), accumulator width per lane.
- CNT_WIDTH, 16, width of emitted-window counter.

Ports:
- s_axis_aclk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- s_axis_tdata  in  64  DDC output: [31:0] I, [63:32] Q, signed two's complement.
- s_axis_tvalid  in  1  sample valid; no tready, input is never stalled.
- resync  in  1  restart accumulation window, clear overflow.
- acc_log2  in  5  window = 2^acc_log2; values >LOG_MAX_ACC clamp to LOG_MAX_ACC.
- m_axis_tdata  out  64  averaged result: [31:0] I, [63:32] Q.
- m_axis_tvalid  out  1  result valid.
- m_axis_tready  in  1  downstream accept.
- overflow  out  1  sticky: a completed window was dropped.
- win_count  out  CNT_WIDTH  number of windows written to the buffer; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset:
  - Accumulators and sample counter are 0; buffer is empty.
  - m_axis_tvalid=0, m_axis_tdata=0, overflow=0, win_count=0.
  - Reset mid-window discards the partial sum and buffer contents.
- Window start:
  - Occurs on the first valid sample after reset, resync, or a completed window.
  - The clamped acc_log2 is latched as shift. Changes to acc_log2 mid-window are ignored until the next window start.
- Accumulation:
  - On each valid sample, sign-extend I and Q to ACC_WIDTH and add.
  - The first sample of a window loads rather than adds.
  - Sample counter increments; the window completes on sample 2^shift.
- Dump:
  - Result per lane = sum >>> shift (arithmetic, floor), truncated to DATA_WIDTH. The result always fits.
  - Written to the buffer at the clock edge ending the cycle after the last sample. If the last sample is presented in cycle t, m_axis_tvalid is high in cycle t+2.
  - win_count increments on each buffer write.
- Window of 1 (shift=0): pass-through with 2-cycle latency; back-to-back results every cycle.
- Output buffer:
  - 2-entry FIFO, in order. Head drives m_axis_tdata/tvalid.
  - Pop on tvalid&&tready.
  - Simultaneous push and pop when full is legal: no drop.
- Overflow:
  - A dump arriving when the buffer is full and not popping that cycle is dropped. overflow is set and win_count does not increment.
  - Cleared by resync or rst. If a drop and resync coincide, set wins.
- Resync:
  - The partial sum is discarded.
  - A valid sample in the same cycle becomes sample 1 of the new window, with acc_log2 latched that cycle.
  - A dump already in the pipeline is still written. The buffer is preserved.
- m_axis_tdata holds stable while tvalid&&!tready (AXI-Stream rule).

Optional Feature:
- Macro DDC_ACC_ROUND_EN.
- When defined:
  - Per lane result = (sum + (1<<(shift-1))) >>> shift for shift>0 (round half up).
  - Results above the DATA_WIDTH signed maximum saturate to 0x7FFFFFFF.
  - shift=0 is unchanged.
- When undefined: floor shift only, no rounding adder, no saturation logic.

Decomposition:
- Package ddc_acc_pkg:
  - DATA_WIDTH, LOG_MAX_ACC and ACC_WIDTH constants.
  - Packed struct iq_t {Q, I} of DATA_WIDTH lanes, with I in the LSBs.
  - Packed struct acc_t of ACC_WIDTH lanes.
  - Function clamp_log2.
- Sub-module ddc_acc_fifo: 2-entry iq_t FIFO with full/empty and simultaneous push/pop. The top level holds the accumulator, counter, shift latch and overflow logic.

Test Plan:
- acc_log2=0, tready=1, constant I=5, Q=-3 every cycle -> every output I=5, Q=0xFFFFFFFD; first tvalid 2 cycles after first sample; win_count increments every cycle.
- acc_log2=2, I=1,2,3,4 and Q=-1,-2,-3,-4 -> one output I=2, Q=-3. With DDC_ACC_ROUND_EN: I=3, Q=-2.
- acc_log2=0, tready=0, 3 valid samples -> tvalid=1 holding sample 1; overflow=1 after sample 3; then tready=1 -> samples 1 and 2 in order; win_count=2.
- acc_log2=3, 5 samples, then resync with a valid sample -> no output for the partial window; next output after 8 samples counted from the resync sample; overflow cleared.
- acc_log2=16, I=Q=0x7FFFFFFF for 65536 samples -> I=Q=0x7FFFFFFF, no wrap. With ROUND_EN: saturates to 0x7FFFFFFF.
- rst asserted mid-window with a full buffer -> next cycle tvalid=0, overflow=0, win_count=0; following window counts from sample 1.
